// File: rtl/calc_sequencer.sv
// Operand-entry and operation sequencer for the sign-magnitude calculator.
// Latches A/B, runs add/sub in one cycle and mul/div iteratively, presents a zero-normalised result.
module calc_sequencer #(
   parameter int MAG_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enter,
   input  logic                 clear,
   input  logic [MAG_W:0]       operandIn,
   input  logic [1:0]           opSel,
   input  logic [2*MAG_W+1:0]   addResult,
   input  logic [2*MAG_W+1:0]   subResult,
   output logic [MAG_W:0]       numberA,
   output logic [MAG_W:0]       numberB,
   output logic [2*MAG_W+1:0]   Result,
   output logic [MAG_W:0]       remainder,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [2:0]           state
);

   localparam int RW = 2*MAG_W + 2;
   localparam int CW = (MAG_W > 1) ? $clog2(MAG_W) : 1;

   typedef enum logic [2:0] {
      WAIT_A = 3'd0,
      WAIT_B = 3'd1,
      EXEC   = 3'd2,
      DONE   = 3'd3,
      ERROR  = 3'd4
   } stateType;

   stateType              curState;
   logic [1:0]            opReg;
   logic [CW-1:0]         iterCnt;
   logic [2*MAG_W-1:0]    accReg;
   logic [MAG_W-1:0]      remReg;
   logic [MAG_W-1:0]      quoReg;

   logic [2*MAG_W-1:0]    nextAcc;
   logic [MAG_W:0]        shiftedRem;
   logic [MAG_W+1:0]      trialDiff;
   logic [MAG_W-1:0]      nextRem;
   logic [MAG_W-1:0]      nextQuo;
   logic                  resSign;
   logic                  lastIter;

   function automatic logic [RW-1:0] normRes(input logic [RW-1:0] v);
      return (v[RW-2:0] == '0) ? '0 : v;
   endfunction

   function automatic logic [MAG_W:0] normRem(input logic [MAG_W:0] v);
      return (v[MAG_W-1:0] == '0) ? '0 : v;
   endfunction

   // One shift-add step (LSB-first over |B|) and one restoring-divide step per EXEC cycle.
   always_comb begin
      nextAcc    = accReg;
      if (numberB[iterCnt])
         nextAcc = accReg + ({{MAG_W{1'b0}}, numberA[MAG_W-1:0]} << iterCnt);
      shiftedRem = {remReg, quoReg[MAG_W-1]};
      trialDiff  = {1'b0, shiftedRem} - {2'b00, numberB[MAG_W-1:0]};
      nextRem    = trialDiff[MAG_W+1] ? shiftedRem[MAG_W-1:0] : trialDiff[MAG_W-1:0];
      nextQuo    = {quoReg[MAG_W-2:0], ~trialDiff[MAG_W+1]};
      resSign    = numberA[MAG_W] ^ numberB[MAG_W];
      lastIter   = (iterCnt == CW'(MAG_W-1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         curState  <= WAIT_A;
         numberA   <= '0;
         numberB   <= '0;
         Result    <= '0;
         remainder <= '0;
         opReg     <= '0;
         iterCnt   <= '0;
         accReg    <= '0;
         remReg    <= '0;
         quoReg    <= '0;
      end else if (clear) begin
         curState  <= WAIT_A;
         numberA   <= '0;
         numberB   <= '0;
         Result    <= '0;
         remainder <= '0;
         opReg     <= '0;
         iterCnt   <= '0;
         accReg    <= '0;
         remReg    <= '0;
         quoReg    <= '0;
      end else begin
         case (curState)
            WAIT_A: if (enter) begin
               numberA  <= operandIn;
               curState <= WAIT_B;
            end
            WAIT_B: if (enter) begin
               numberB <= operandIn;
               opReg   <= opSel;
               iterCnt <= '0;
               accReg  <= '0;
               remReg  <= '0;
               quoReg  <= numberA[MAG_W-1:0];
               if (opSel == 2'b11 && operandIn[MAG_W-1:0] == '0) begin
                  Result    <= '0;
                  remainder <= '0;
                  curState  <= ERROR;
               end else begin
                  curState <= EXEC;
               end
            end
            EXEC: begin
               case (opReg)
                  2'b00: begin
                     Result    <= normRes(addResult);
                     remainder <= '0;
                     curState  <= DONE;
                  end
                  2'b01: begin
                     Result    <= normRes(subResult);
                     remainder <= '0;
                     curState  <= DONE;
                  end
                  2'b10: begin
                     accReg  <= nextAcc;
                     iterCnt <= iterCnt + 1'b1;
                     if (lastIter) begin
                        Result    <= normRes({resSign, 1'b0, nextAcc});
                        remainder <= '0;
                        curState  <= DONE;
                     end
                  end
                  default: begin
                     remReg  <= nextRem;
                     quoReg  <= nextQuo;
                     iterCnt <= iterCnt + 1'b1;
                     if (lastIter) begin
                        Result    <= normRes({resSign, {(MAG_W+1){1'b0}}, nextQuo});
                        remainder <= normRem({numberA[MAG_W], nextRem});
                        curState  <= DONE;
                     end
                  end
               endcase
            end
            DONE: if (enter) begin
               numberA  <= operandIn;
               curState <= WAIT_B;
            end
            ERROR: if (enter) curState <= WAIT_A;
            default: curState <= WAIT_A;
         endcase
      end
   end

   assign state = curState;
   assign busy  = (curState == EXEC);
   assign done  = (curState == DONE);
   assign error = (curState == ERROR);

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: add/sub/mul/div, zero normalisation, chaining, clear and reset.
module tb_calc_sequencer;

   localparam int MAG_W = 8;

   logic                clk = 1'b0;
   logic                reset;
   logic                enter;
   logic                clear;
   logic [MAG_W:0]      operandIn;
   logic [1:0]          opSel;
   logic [2*MAG_W+1:0]  addResult;
   logic [2*MAG_W+1:0]  subResult;
   logic [MAG_W:0]      numberA;
   logic [MAG_W:0]      numberB;
   logic [2*MAG_W+1:0]  Result;
   logic [MAG_W:0]      remainder;
   logic                busy;
   logic                done;
   logic                error;
   logic [2:0]          state;

   int checks = 0;
   int errors = 0;
   int nBusy;

   calc_sequencer #(.MAG_W(MAG_W)) dut (
      .clk(clk), .reset(reset), .enter(enter), .clear(clear),
      .operandIn(operandIn), .opSel(opSel),
      .addResult(addResult), .subResult(subResult),
      .numberA(numberA), .numberB(numberB), .Result(Result),
      .remainder(remainder), .busy(busy), .done(done),
      .error(error), .state(state)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pressEnter(input logic [MAG_W:0] val, input logic [1:0] op);
      operandIn = val;
      opSel     = op;
      enter     = 1'b1;
      step();
      enter     = 1'b0;
   endtask

   task automatic countBusy(output int n);
      n = 0;
      while (busy && n < 40) begin
         n++;
         step();
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; enter = 1'b0; clear = 1'b0;
      operandIn = '0; opSel = '0;
      addResult = 18'd65;
      subResult = {1'b1, 17'd0};
      #12;
      check("rst_state", state, 0);
      check("rst_result", Result, 0);
      check("rst_flags", {busy, done, error}, 0);
      check("rst_numA", numberA, 0);
      step();
      reset = 1'b0;
      step();

      // add: +25 + -40 with stubbed +65
      pressEnter(9'h019, 2'b00);
      check("add_waitb", state, 1);
      pressEnter({1'b1, 8'd40}, 2'b00);
      check("add_exec", state, 2);
      countBusy(nBusy);
      check("add_busy_cycles", nBusy, 1);
      check("add_done", done, 1);
      check("add_result", Result, 18'd65);
      check("add_rem", remainder, 0);

      // sub -5 - -5 yields negative-zero stub, normalised to +0
      pressEnter({1'b1, 8'd5}, 2'b00);
      pressEnter({1'b1, 8'd5}, 2'b01);
      countBusy(nBusy);
      check("sub_state", state, 3);
      check("sub_zero", Result, 18'd0);

      // mul -255 * +255
      pressEnter({1'b1, 8'd255}, 2'b00);
      pressEnter({1'b0, 8'd255}, 2'b10);
      countBusy(nBusy);
      check("mul_busy_cycles", nBusy, 8);
      check("mul_done", done, 1);
      check("mul_result", Result, {1'b1, 17'd65025});

      // div -100 / +7
      pressEnter({1'b1, 8'd100}, 2'b00);
      pressEnter({1'b0, 8'd7}, 2'b11);
      countBusy(nBusy);
      check("div_busy_cycles", nBusy, 8);
      check("div_result", Result, {1'b1, 17'd14});
      check("div_rem", remainder, {1'b1, 8'd2});

      // chaining from DONE, then enter pulses ignored during mul EXEC
      pressEnter({1'b0, 8'd3}, 2'b00);
      check("chain_numA", numberA, {1'b0, 8'd3});
      check("chain_state", state, 1);
      pressEnter({1'b0, 8'd5}, 2'b10);
      step();
      step();
      pressEnter({1'b0, 8'hAA}, 2'b00);
      check("ign_state", state, 2);
      countBusy(nBusy);
      check("ign_busy_rest", nBusy, 5);
      check("ign_numB", numberB, {1'b0, 8'd5});
      check("ign_result", Result, 18'd15);
      check("ign_rem_zero", remainder, 0);

      // clear during 4th EXEC cycle of mul
      pressEnter({1'b0, 8'd3}, 2'b00);
      pressEnter({1'b0, 8'd5}, 2'b10);
      step(); step(); step();
      check("clr_pre_busy", busy, 1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clr_state", state, 0);
      check("clr_result", Result, 0);
      check("clr_nums", {numberA, numberB}, 0);
      check("clr_flags", {busy, done, error}, 0);

      // divide by (negative) zero
      pressEnter({1'b0, 8'd50}, 2'b00);
      pressEnter({1'b1, 8'd0}, 2'b11);
      check("dz_state", state, 4);
      check("dz_error", error, 1);
      check("dz_result", Result, 0);
      pressEnter({1'b0, 8'd1}, 2'b00);
      check("dz_exit_state", state, 0);
      check("dz_exit_error", error, 0);

      // async reset mid-EXEC
      pressEnter({1'b0, 8'd3}, 2'b00);
      pressEnter({1'b0, 8'd5}, 2'b10);
      step();
      #2;
      reset = 1'b1;
      #1;
      check("ar_state", state, 0);
      check("ar_busy", busy, 0);
      check("ar_nums", {numberA, numberB}, 0);
      step();
      reset = 1'b0;
      step();
      check("ar_hold_state", state, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
